// File: rtl/mdu_pkg.sv
// Shared MADOP encodings, default latencies and FSM state type for the E-stage multiply/divide unit.
package mdu_pkg;

   localparam logic [3:0] MDU_NONE  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_MTHI  = 4'd3;
   localparam logic [3:0] MDU_MTLO  = 4'd4;
   localparam logic [3:0] MDU_DIV   = 4'd5;
   localparam logic [3:0] MDU_DIVU  = 4'd6;
   localparam logic [3:0] MDU_MADD  = 4'd7;
   localparam logic [3:0] MDU_MADDU = 4'd8;

   localparam int unsigned MULT_LAT_DEF = 5;
   localparam int unsigned DIV_LAT_DEF  = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

endpackage

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit owning HI/LO; MADD/MADDU exist only when MDU_MADD_EN is defined.
// Latency: MULT/MADD hold Busy MULT_LAT cycles, DIV DIV_LAT cycles; MTHI/MTLO write at the next edge.
// Backpressure: none issued here; the hazard unit stalls HI/LO instructions while Start|Busy.
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MADOP,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   input  logic        Req,
   output logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W = $clog2(MAX_LAT + 1);
   typedef logic [CNT_W-1:0] cnt_t;

   mdu_state_e  state_q, state_d;
   cnt_t        cnt_q, cnt_d;
   logic [63:0] pend_q, pend_d;
   logic        pend_wr_q, pend_wr_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;

   logic is_mul_s, is_mul_u, is_div_s, is_div_u;
   logic is_madd_s, is_madd_u, is_mthi, is_mtlo;
   logic is_long, is_div;

   always_comb begin
      is_mul_s  = 1'b0;
      is_mul_u  = 1'b0;
      is_div_s  = 1'b0;
      is_div_u  = 1'b0;
      is_madd_s = 1'b0;
      is_madd_u = 1'b0;
      is_mthi   = 1'b0;
      is_mtlo   = 1'b0;
      case (MADOP)
         MDU_MULT:  is_mul_s  = 1'b1;
         MDU_MULTU: is_mul_u  = 1'b1;
         MDU_MTHI:  is_mthi   = 1'b1;
         MDU_MTLO:  is_mtlo   = 1'b1;
         MDU_DIV:   is_div_s  = 1'b1;
         MDU_DIVU:  is_div_u  = 1'b1;
`ifdef MDU_MADD_EN
         MDU_MADD:  is_madd_s = 1'b1;
         MDU_MADDU: is_madd_u = 1'b1;
`endif
         default: ;
      endcase
   end

   assign is_div  = is_div_s | is_div_u;
   assign is_long = is_mul_s | is_mul_u | is_div | is_madd_s | is_madd_u;
   assign Busy    = (state_q == ST_RUN);
   assign Start   = is_long & ~Req & ~Busy;
   assign HI      = hi_q;
   assign LO      = lo_q;

   logic [63:0] a_sx, b_sx, prod_s, prod_u;
   logic [31:0] a_mag, b_mag, q_mag, r_mag;
   logic [31:0] quot_s, rem_s, quot_u, rem_u;
   logic        div_ok;

   assign a_sx   = {{32{SrcA[31]}}, SrcA};
   assign b_sx   = {{32{SrcB[31]}}, SrcB};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'b0, SrcA} * {32'b0, SrcB};

   // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow case.
   assign div_ok = (SrcB != 32'b0);
   assign a_mag  = SrcA[31] ? (32'b0 - SrcA) : SrcA;
   assign b_mag  = SrcB[31] ? (32'b0 - SrcB) : SrcB;
   assign q_mag  = div_ok ? (a_mag / b_mag) : 32'b0;
   assign r_mag  = div_ok ? (a_mag % b_mag) : 32'b0;
   assign quot_s = (SrcA[31] ^ SrcB[31]) ? (32'b0 - q_mag) : q_mag;
   assign rem_s  = SrcA[31] ? (32'b0 - r_mag) : r_mag;
   assign quot_u = div_ok ? (SrcA / SrcB) : 32'b0;
   assign rem_u  = div_ok ? (SrcA % SrcB) : 32'b0;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      pend_wr_d = pend_wr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               state_d   = ST_RUN;
               cnt_d     = is_div ? cnt_t'(DIV_LAT) : cnt_t'(MULT_LAT);
               pend_wr_d = 1'b1;
               if (is_mul_s) begin
                  pend_d = prod_s;
               end else if (is_mul_u) begin
                  pend_d = prod_u;
               end else if (is_div_s) begin
                  pend_d    = {rem_s, quot_s};
                  pend_wr_d = div_ok;
               end else if (is_div_u) begin
                  pend_d    = {rem_u, quot_u};
                  pend_wr_d = div_ok;
               end else if (is_madd_s) begin
                  pend_d = {hi_q, lo_q} + prod_s;
               end else begin
                  pend_d = {hi_q, lo_q} + prod_u;
               end
            end else if (!Req) begin
               if (is_mthi) hi_d = SrcA;
               if (is_mtlo) lo_d = SrcA;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == cnt_t'(1)) begin
               state_d = ST_IDLE;
               if (pend_wr_q) begin
                  hi_d = pend_q[63:32];
                  lo_d = pend_q[31:0];
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pend_q    <= '0;
         pend_wr_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         pend_wr_q <= pend_wr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: expected {HI,LO} results queue at issue and are checked at completion.
module tb_mdu_unit;
   import mdu_pkg::*;

   logic        clk;
   logic        reset;
   logic [3:0]  MADOP;
   logic [31:0] SrcA, SrcB;
   logic        Req;
   logic        Start, Busy;
   logic [31:0] HI, LO;

   int ncmp  = 0;
   int nfail = 0;
   logic [63:0] sb_q[$];
   logic [63:0] cur_hl;

   mdu_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk(clk), .reset(reset), .MADOP(MADOP), .SrcA(SrcA), .SrcB(SrcB),
      .Req(Req), .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge following the Start edge.
   task automatic start_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_hl);
      MADOP = op; SrcA = a; SrcB = b; Req = 1'b0;
      #1;
      chk({tag, "_start"}, {63'b0, Start}, 64'd1);
      sb_q.push_back(exp_hl);
      @(negedge clk);
      MADOP = MDU_NONE;
      #1;
      chk({tag, "_start_low_in_run"}, {63'b0, Start}, 64'd0);
      chk({tag, "_hilo_hold"}, {HI, LO}, cur_hl);
   endtask

   task automatic finish_op(input string tag, input int lat_left);
      int cnt;
      logic [63:0] exp_hl;
      cnt = 0;
      while (Busy === 1'b1 && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      chk({tag, "_busy_cycles"}, 64'(cnt), 64'(lat_left));
      if (sb_q.size() == 0) begin
         exp_hl = ~cur_hl;
         $error("FAIL %s_scoreboard: observed=empty expected=entry", tag);
      end else begin
         exp_hl = sb_q.pop_front();
      end
      chk({tag, "_result"}, {HI, LO}, exp_hl);
      cur_hl = exp_hl;
   endtask

   initial begin
      reset = 1'b0; MADOP = MDU_NONE; SrcA = '0; SrcB = '0; Req = 1'b0;
      cur_hl = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", {63'b0, Busy}, 64'd0);
      chk("reset_hilo", {HI, LO}, 64'd0);
      chk("reset_start", {63'b0, Start}, 64'd0);
      reset = 1'b1;
      @(negedge clk);

      start_op("mult", MDU_MULT, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
      finish_op("mult", 5);
      start_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE});
      finish_op("multu", 5);
      start_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      finish_op("div", 10);
      start_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
      finish_op("div_ovf", 10);

      MADOP = MDU_MTHI; SrcA = 32'h1234;
      @(negedge clk);
      MADOP = MDU_MTLO; SrcA = 32'h5678;
      @(negedge clk);
      MADOP = MDU_NONE;
      cur_hl = {32'h1234, 32'h5678};
      chk("mthi_mtlo", {HI, LO}, cur_hl);
      chk("mt_busy", {63'b0, Busy}, 64'd0);

      start_op("divu_zero", MDU_DIVU, 32'hDEAD_BEEF, 32'd0, cur_hl);
      finish_op("divu_zero", 10);

      MADOP = MDU_MULT; SrcA = 32'd3; SrcB = 32'd4; Req = 1'b1;
      #1;
      chk("req_mult_start", {63'b0, Start}, 64'd0);
      @(negedge clk);
      chk("req_mult_busy", {63'b0, Busy}, 64'd0);
      chk("req_mult_hilo", {HI, LO}, cur_hl);
      MADOP = MDU_MTLO; SrcA = 32'hAA;
      @(negedge clk);
      chk("req_mtlo", {HI, LO}, cur_hl);
      MADOP = MDU_NONE; Req = 1'b0;

      start_op("divu_req", MDU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
      MADOP = MDU_MTLO; SrcA = 32'hDEAD;
      @(negedge clk);
      chk("mt_while_busy", {HI, LO}, cur_hl);
      MADOP = MDU_NONE; Req = 1'b1;
      @(negedge clk);
      Req = 1'b0;
      finish_op("divu_req", 8);

`ifdef MDU_MADD_EN
      MADOP = MDU_MTHI; SrcA = 32'h0;
      @(negedge clk);
      MADOP = MDU_MTLO; SrcA = 32'hFFFF_FFFF;
      @(negedge clk);
      MADOP = MDU_NONE;
      cur_hl = {32'h0, 32'hFFFF_FFFF};
      start_op("maddu", MDU_MADDU, 32'd1, 32'd1, {32'd1, 32'd0});
      finish_op("maddu", 5);
`else
      MADOP = MDU_MADD; SrcA = 32'd5; SrcB = 32'd6;
      #1;
      chk("madd_off_start", {63'b0, Start}, 64'd0);
      @(negedge clk);
      MADOP = MDU_NONE;
      chk("madd_off_busy", {63'b0, Busy}, 64'd0);
      chk("madd_off_hilo", {HI, LO}, cur_hl);
`endif

      MADOP = MDU_MULT; SrcA = 32'd3; SrcB = 32'd5;
      #1;
      chk("rst_run_start", {63'b0, Start}, 64'd1);
      @(negedge clk);
      MADOP = MDU_NONE;
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      chk("rst_run_busy", {63'b0, Busy}, 64'd0);
      chk("rst_run_hilo", {HI, LO}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      chk("rst_run_no_write", {HI, LO}, 64'd0);
      chk("rst_run_idle", {63'b0, Busy}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
